// File: rtl/snake_dir_ctrl_if.sv
// snake_dir_ctrl_if: key levels and game tick in; heading, step strobe and queue status out.
interface snake_dir_ctrl_if #(
   parameter int unsigned QDEPTH = 2
);
   logic                    right;
   logic                    left;
   logic                    up;
   logic                    down;
   logic                    tick;
   logic [1:0]              dir;
   logic                    step;
   logic [$clog2(QDEPTH):0] q_cnt;
   logic                    drop;

   modport master (
      output right, left, up, down, tick,
      input  dir, step, q_cnt, drop
   );

   modport slave (
      input  right, left, up, down, tick,
      output dir, step, q_cnt, drop
   );
endinterface

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: edge-detects direction keys, filters redundant turns, queues them and applies one per tick.
// Build option: define SNAKE_REV_FILTER_EN to also reject turns opposite to the reference heading.
module snake_dir_ctrl #(
   parameter int unsigned QDEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   snake_dir_ctrl_if.slave bus
);
   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;

   logic [3:0]    r_k_q;
   logic [1:0]    r_dir;
   logic          r_step;
   logic          r_drop;
   logic [CW-1:0] r_cnt;
   logic [PW-1:0] r_rptr;
   logic [PW-1:0] r_wptr;
   logic [1:0]    r_fifo [QDEPTH];

   logic [3:0]    w_keys;
   logic [3:0]    w_edge;
   logic          w_cand_vld;
   logic [1:0]    w_cand;
   logic [PW-1:0] w_tail_idx;
   logic [1:0]    w_ref;
   logic          w_rev_hit;
   logic          w_full;
   logic          w_pop;
   logic          w_reject;
   logic          w_push;

   assign w_keys = {bus.right, bus.left, bus.up, bus.down};
   assign w_edge = w_keys & ~r_k_q;

   // Only the highest-priority edge is a candidate; lower ones vanish silently.
   always_comb begin
      w_cand_vld = 1'b1;
      w_cand     = 2'b00;
      if (w_edge[3])      w_cand = 2'b00;
      else if (w_edge[2]) w_cand = 2'b01;
      else if (w_edge[1]) w_cand = 2'b10;
      else if (w_edge[0]) w_cand = 2'b11;
      else                w_cand_vld = 1'b0;
   end

   // Reference is the most recently queued turn, sampled before this cycle's pop.
   assign w_tail_idx = r_wptr - PW'(1);
   assign w_ref      = (r_cnt != '0) ? r_fifo[w_tail_idx] : r_dir;

`ifdef SNAKE_REV_FILTER_EN
   assign w_rev_hit = (w_cand == {w_ref[1], ~w_ref[0]});
`else
   assign w_rev_hit = 1'b0;
`endif

   assign w_full   = (r_cnt == CW'(QDEPTH));
   assign w_pop    = bus.tick && (r_cnt != '0);
   assign w_reject = (w_cand == w_ref) || w_rev_hit || (w_full && !w_pop);
   assign w_push   = w_cand_vld && !w_reject;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k_q  <= '0;
         r_dir  <= 2'b00;
         r_step <= 1'b0;
         r_drop <= 1'b0;
         r_cnt  <= '0;
         r_rptr <= '0;
         r_wptr <= '0;
      end else begin
         r_k_q  <= w_keys;
         r_step <= bus.tick;
         r_drop <= w_cand_vld && w_reject;
         if (w_pop) begin
            r_dir  <= r_fifo[r_rptr];
            r_rptr <= r_rptr + PW'(1);
         end
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage needs no reset: entries are only read while counted as valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wptr] <= w_cand;
      end
   end

   assign bus.dir   = r_dir;
   assign bus.step  = r_step;
   assign bus.q_cnt = r_cnt;
   assign bus.drop  = r_drop;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: directed scenarios and random stimulus checked against a queue-based heading model.
module tb_snake_dir_ctrl;
   localparam int unsigned QD = 2;
   localparam int unsigned CW = $clog2(QD) + 1;
   localparam logic [3:0] K_R = 4'b1000;
   localparam logic [3:0] K_L = 4'b0100;
   localparam logic [3:0] K_U = 4'b0010;
   localparam logic [3:0] K_D = 4'b0001;
   localparam logic [3:0] K_0 = 4'b0000;
`ifdef SNAKE_REV_FILTER_EN
   localparam bit REV_EN = 1'b1;
`else
   localparam bit REV_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   snake_dir_ctrl_if #(.QDEPTH(QD)) bus ();
   snake_dir_ctrl #(.QDEPTH(QD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   // Model: heading plus a queue of pending turns; keys listed in priority order, code = list position.
   logic [1:0] m_dir  = 2'b00;
   logic       m_step = 1'b0;
   logic       m_drop = 1'b0;
   logic [3:0] m_kq   = 4'b0000;
   logic [1:0] mq[$];

   task automatic model_reset();
      m_dir  = 2'b00;
      m_step = 1'b0;
      m_drop = 1'b0;
      m_kq   = 4'b0000;
      mq.delete();
   endtask

   task automatic model_step(input logic [3:0] k, input logic t);
      logic [3:0] ev;
      logic [1:0] c;
      logic [1:0] rf;
      bit         cv;
      bit         pop;
      bit         opposite;
      bit         rej;
      ev = k & ~m_kq;
      cv = 1'b0;
      c  = 2'b00;
      for (int i = 0; i < 4; i++) begin
         if (!cv && ev[3-i]) begin
            cv = 1'b1;
            c  = 2'(i);
         end
      end
      rf       = (mq.size() != 0) ? mq[$] : m_dir;
      pop      = t && (mq.size() != 0);
      opposite = (c != rf) && (c[1] == rf[1]);
      rej      = (c == rf) || (REV_EN && opposite) || ((mq.size() == QD) && !pop);
      m_drop   = cv && rej;
      m_step   = t;
      if (pop) m_dir = mq.pop_front();
      if (cv && !rej) mq.push_back(c);
      m_kq = k;
   endtask

   task automatic cycle(input logic [3:0] k, input logic t);
      {bus.right, bus.left, bus.up, bus.down} = k;
      bus.tick = t;
      @(posedge clk);
      model_step(k, t);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      {bus.right, bus.left, bus.up, bus.down} = K_0;
      bus.tick = 1'b0;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      {bus.right, bus.left, bus.up, bus.down} = K_0;
      bus.tick = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #3;
      checks++;
      if ({bus.dir, bus.q_cnt} !== {2'b00, CW'(0)}) begin
         errors++;
         $display("FAIL reset_dir_cnt: dir=%0d q_cnt=%0d expected 0/0", bus.dir, bus.q_cnt);
      end
      checks++;
      if ({bus.step, bus.drop} !== 2'b00) begin
         errors++;
         $display("FAIL reset_pulses: step=%0d drop=%0d expected 0/0", bus.step, bus.drop);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle(K_0, 1'b1);
         checks++;
         if ({bus.dir, bus.step, bus.q_cnt, bus.drop} !== {2'b00, 1'b1, CW'(0), 1'b0}) begin
            errors++;
            $display("FAIL reset_idle_tick%0d: dir=%0d step=%0d q_cnt=%0d drop=%0d expected 0/1/0/0",
                     i, bus.dir, bus.step, bus.q_cnt, bus.drop);
         end
      end
   endtask

   task automatic test_turns();
      logic [3:0] k  [5] = '{K_U, K_U, K_0, K_L, K_0};
      logic       t  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [1:0] ed [5] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd1};
      int         eq [5] = '{1, 0, 0, 1, 0};
      for (int i = 0; i < 5; i++) begin
         cycle(k[i], t[i]);
         checks++;
         if ({bus.dir, bus.step, bus.q_cnt, bus.drop} !== {ed[i], t[i], CW'(eq[i]), 1'b0}) begin
            errors++;
            $display("FAIL turns_%0d: dir/step/q_cnt/drop=%0d/%0d/%0d/%0d expected %0d/%0d/%0d/0",
                     i, bus.dir, bus.step, bus.q_cnt, bus.drop, ed[i], t[i], eq[i]);
         end
      end
   endtask

   task automatic test_reverse();
      logic [3:0] k [3] = '{K_L, K_0, K_0};
      logic       t [3] = '{1'b0, 1'b0, 1'b1};
      logic       edrop;
      logic [1:0] edir;
      int         eq;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(k[i], t[i]);
         edrop = (i == 0) && REV_EN;
         eq    = (!REV_EN && i < 2) ? 1 : 0;
         edir  = (!REV_EN && i == 2) ? 2'd1 : 2'd0;
         checks++;
         if ({bus.dir, bus.q_cnt, bus.drop} !== {edir, CW'(eq), edrop}) begin
            errors++;
            $display("FAIL reverse_%0d: dir/q_cnt/drop=%0d/%0d/%0d expected %0d/%0d/%0d",
                     i, bus.dir, bus.q_cnt, bus.drop, edir, eq, edrop);
         end
      end
   endtask

   task automatic test_full();
      logic [3:0] k [9] = '{K_U, K_0, K_D, K_0, K_R, K_0, K_U, K_0, K_0};
      logic       t [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      apply_reset();
      for (int i = 0; i < 9; i++) begin
         cycle(k[i], t[i]);
         checks++;
         if ({bus.dir, bus.step, bus.q_cnt, bus.drop} !== {m_dir, m_step, CW'(mq.size()), m_drop}) begin
            errors++;
            $display("FAIL full_model_%0d: dir/step/q_cnt/drop=%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                     i, bus.dir, bus.step, bus.q_cnt, bus.drop, m_dir, m_step, mq.size(), m_drop);
         end
         if (i == 6) begin
            checks++;
            if ({bus.q_cnt, bus.drop} !== {CW'(2), 1'b1}) begin
               errors++;
               $display("FAIL full_drop: q_cnt=%0d drop=%0d expected 2/1", bus.q_cnt, bus.drop);
            end
         end
         if (i == 8) begin
            checks++;
            if (bus.dir !== (REV_EN ? 2'd0 : 2'd3)) begin
               errors++;
               $display("FAIL full_second_pop: dir=%0d expected %0d", bus.dir, REV_EN ? 0 : 3);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] k  [7] = '{K_U, K_0, K_R, K_0, K_D, K_0, K_0};
      logic       t  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [1:0] ed [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd3};
      int         eq [7] = '{1, 1, 2, 2, 2, 1, 0};
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         cycle(k[i], t[i]);
         checks++;
         if ({bus.dir, bus.step, bus.q_cnt, bus.drop} !== {ed[i], t[i], CW'(eq[i]), 1'b0}) begin
            errors++;
            $display("FAIL back_to_back_%0d: dir/step/q_cnt/drop=%0d/%0d/%0d/%0d expected %0d/%0d/%0d/0",
                     i, bus.dir, bus.step, bus.q_cnt, bus.drop, ed[i], t[i], eq[i]);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] k  [4] = '{K_U, K_0, K_R | K_U, K_0};
      logic       t  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic [1:0] ed [4] = '{2'd0, 2'd2, 2'd2, 2'd0};
      int         eq [4] = '{1, 0, 1, 0};
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(k[i], t[i]);
         checks++;
         if ({bus.dir, bus.step, bus.q_cnt, bus.drop} !== {ed[i], t[i], CW'(eq[i]), 1'b0}) begin
            errors++;
            $display("FAIL simultaneous_%0d: dir/step/q_cnt/drop=%0d/%0d/%0d/%0d expected %0d/%0d/%0d/0",
                     i, bus.dir, bus.step, bus.q_cnt, bus.drop, ed[i], t[i], eq[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      cycle(K_U, 1'b1);
      cycle(K_0, 1'b1);
      cycle(K_R, 1'b0);
      cycle(K_0, 1'b0);
      cycle(K_D, 1'b0);
      checks++;
      if ({bus.dir, bus.q_cnt} !== {2'd2, CW'(2)}) begin
         errors++;
         $display("FAIL async_setup: dir=%0d q_cnt=%0d expected 2/2", bus.dir, bus.q_cnt);
      end
      {bus.right, bus.left, bus.up, bus.down} = K_U;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({bus.dir, bus.q_cnt} !== {2'd0, CW'(0)}) begin
         errors++;
         $display("FAIL async_clear: dir=%0d q_cnt=%0d expected 0/0", bus.dir, bus.q_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cycle(K_U, 1'b1);
      checks++;
      if ({bus.dir, bus.step, bus.q_cnt, bus.drop} !== {2'd0, 1'b1, CW'(1), 1'b0}) begin
         errors++;
         $display("FAIL async_held_key: dir/step/q_cnt/drop=%0d/%0d/%0d/%0d expected 0/1/1/0",
                  bus.dir, bus.step, bus.q_cnt, bus.drop);
      end
      cycle(K_0, 1'b1);
      checks++;
      if ({bus.dir, bus.q_cnt} !== {2'd2, CW'(0)}) begin
         errors++;
         $display("FAIL async_after: dir=%0d q_cnt=%0d expected 2/0", bus.dir, bus.q_cnt);
      end
   endtask

   task automatic test_random();
      logic [3:0] k;
      logic       t;
      apply_reset();
      k = K_0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) == 0) k = 4'($urandom_range(0, 15));
         t = ($urandom_range(0, 3) == 0);
         cycle(k, t);
         checks++;
         if ({bus.dir, bus.step, bus.q_cnt, bus.drop} !== {m_dir, m_step, CW'(mq.size()), m_drop}) begin
            errors++;
            $display("FAIL random_%0d: dir/step/q_cnt/drop=%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                     i, bus.dir, bus.step, bus.q_cnt, bus.drop, m_dir, m_step, mq.size(), m_drop);
         end
      end
   endtask

   initial begin
      test_reset();
      test_turns();
      test_reverse();
      test_full();
      test_back_to_back();
      test_simultaneous();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/snake_dir_ctrl.md
# snake_dir_ctrl

Direction controller sitting directly downstream of the PS/2 keyboard front end. It consumes the `right`/`left`/`up`/`down` key levels, edge-detects them, and filters out redundant and reversing turns. Accepted turns are buffered in a small FIFO and applied one per game tick. It produces the registered heading and a step strobe consumed by the snake movement/body logic.

## Interface
- `QDEPTH`, 2: turn-queue depth; power of two, 2..8.
- `clk` input 1: system clock; same domain as the keyboard front end.
- `rst_n` input 1: reset, asynchronous, active-low.
- `right`, `left`, `up`, `down` input 1 each: key levels from the keyboard block; high while held.
- `tick` input 1: one-cycle game-step pulse from the game timer.
- `dir` output 2: current heading; 00 right, 01 left, 10 up, 11 down.
- `step` output 1: one-cycle pulse; `dir` is valid for this step.
- `q_cnt` output $clog2(QDEPTH)+1: number of queued turns.
- `drop` output 1: one-cycle pulse when a key edge is discarded.

## Operation
- Key inputs are registered once into `k_q`. A press event is `key & ~k_q`, a rising edge.
- Simultaneous press events in one cycle: at most one is considered. Priority is right > left > up > down, and the rest are ignored without asserting `drop`.
- Reference direction: `ref = (q_cnt != 0) ? tail_entry : dir`. The reference is sampled before this cycle's pop.
- Opposite of `d` is `{d[1], ~d[0]}`.
- Candidate `c` is rejected (`drop`=1) when any of these holds:
  - `c == ref`;
  - `c` is the opposite of `ref` (see Configuration);
  - the queue is full and no pop happens this cycle.
- Otherwise `c` is pushed at the tail.
- On `tick` with `q_cnt != 0`: pop the head into `dir`.
- On `tick` with the queue empty: `dir` is held.
- Every `tick` produces `step`, whether or not a pop occurred.
- Push and pop in the same cycle: both take effect and `q_cnt` is unchanged. A push into a full queue is allowed when a pop happens that cycle.
- FIFO is circular with read/write pointers of width $clog2(QDEPTH). Pointers wrap modulo QDEPTH, and `q_cnt` is tracked separately.
- Reset values:
  - `dir`=00 (right);
  - `step`=0, `drop`=0;
  - `q_cnt`=0 and pointers 0;
  - `k_q`=0.
- A key already held when reset releases produces an edge on the first cycle after reset.
- Reset mid-operation discards all queued turns immediately and asynchronously.

## Timing
- Key level high at edge N → `k_q` compared at N. Push visible in `q_cnt` at N+1.
- `drop` is registered and asserts at N+1 for a rejection evaluated at N.
- `tick` sampled at edge N → `dir` updated and `step`=1 during cycle N+1.
- Consecutive ticks on back-to-back cycles pop back-to-back entries.
- Key-to-heading latency, with an empty queue and a tick in the same cycle as the edge:
  - the push and the pop do not bypass each other;
  - the turn is pushed at N and applied on the next tick.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `SNAKE_REV_FILTER_EN` defined: turns opposite to `ref` are rejected and pulse `drop`.
- `SNAKE_REV_FILTER_EN` undefined: opposite turns are queued like any other accepted turn. The downstream collision logic handles self-reversal.
- Equal-direction rejection and full-queue rejection are unaffected by the macro.

## Test plan
- Reset, then 3 ticks with no keys → `dir`=00, 3 `step` pulses, `q_cnt`=0, `drop` never high.
- From `dir`=00: press up, tick, release, press left, tick → `dir`=10 after the first step and 01 after the second, each taking effect the cycle after its tick.
- From `dir`=00 with `SNAKE_REV_FILTER_EN`: press left → `drop` pulses once and `q_cnt` stays 0. Without the macro: `q_cnt`=1, and the next tick sets `dir`=01.
- QDEPTH=2, no ticks: press up, down→ wait, press right, press up. Expected:
  - up is queued;
  - down is dropped as a reversal (filter on);
  - right is queued, giving `q_cnt`=2;
  - the last up is dropped because the queue is full.
  Then on successive ticks `dir` becomes 10, then 00.
- Queue full, then a tick coinciding with a new valid edge → pop and push in the same cycle, `q_cnt` stays 2, no `drop`.
- Right and up rising in the same cycle from `dir`=10 → only right is considered and queued. No `drop` is asserted for up.
- Assert `rst_n` low mid-cycle with `q_cnt`=2 → `dir`=00 and `q_cnt`=0 immediately without waiting for a clock edge. The next tick after release gives `step` with `dir`=00.
